// File: rtl/pakin_asm_pkg.sv
// rtl/pakin_asm_pkg.sv - shared sizes, FSM encoding and helpers for the packet-input assembler
package pakin_asm_pkg;

  localparam int PSZ_DEF = 4;
  localparam int ASZ_DEF = 6;
  localparam int DSZ_DEF = 8;
  localparam int RSZ_DEF = 4;
  localparam int ERR_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_CHECK   = 2'd1,
    ST_SEND    = 2'd2,
    ST_DRAIN   = 2'd3
  } state_e;

  // Counter width that stays legal even for a single-packet message.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pakin_asm_calc_redun.sv
// rtl/pakin_asm_calc_redun.sv - redundancy field generator: XOR fold of {dat,dst,src} into RSZ bits
module calc_redun #(
  parameter int ASZ = 6,
  parameter int DSZ = 8,
  parameter int RSZ = 4
) (
  input  logic [ASZ-1:0] src_i,
  input  logic [ASZ-1:0] dst_i,
  input  logic [DSZ-1:0] dat_i,
  output logic [RSZ-1:0] red_o
);

  localparam int VW  = 2*ASZ + DSZ;
  localparam int NCH = (VW + RSZ - 1) / RSZ;

  logic [NCH*RSZ-1:0] padded;

  always_comb begin
    padded         = '0;
    padded[VW-1:0] = {dat_i, dst_i, src_i};
    red_o          = '0;
    for (int k = 0; k < NCH; k++) begin
      red_o = red_o ^ padded[k*RSZ +: RSZ];
    end
  end

endmodule

// File: rtl/pakin_asm.sv
// rtl/pakin_asm.sv - reassembles req/ack packets into messages, checks redundancy, forwards good messages
module pakin_asm
  import pakin_asm_pkg::*;
#(
  parameter int PSZ = PSZ_DEF,
  parameter int ASZ = ASZ_DEF,
  parameter int DSZ = DSZ_DEF,
  parameter int RSZ = RSZ_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PSZ:0]         i_pakio,
  input  logic                 i_req,
  output logic                 i_ack,
  output logic [ASZ-1:0]       o_src,
  output logic [ASZ-1:0]       o_dst,
  output logic [DSZ-1:0]       o_dat,
  output logic [RSZ-1:0]       o_red,
  output logic                 o_req,
  input  logic                 o_ack,
  output logic                 err_redun,
  output logic                 err_seq,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int MSG_SZ  = 2*ASZ + DSZ + RSZ;
  localparam int TOT_PKS = (MSG_SZ + PSZ - 1) / PSZ;
  localparam int CW      = cnt_w(TOT_PKS);
  localparam logic [CW-1:0] LAST_PK = CW'(TOT_PKS - 1);

  state_e state_q, state_d;
  logic [CW-1:0]        pk_cnt_q, pk_cnt_d;
  logic [PSZ-1:0]       pk_q [TOT_PKS];
  logic [PSZ-1:0]       pk_d [TOT_PKS];
  logic                 i_ack_q, i_ack_d;
  logic [ASZ-1:0]       src_q, dst_q;
  logic [DSZ-1:0]       dat_q;
  logic [RSZ-1:0]       red_q;
  logic                 err_redun_q, err_redun_d;
  logic                 err_seq_q, err_seq_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [TOT_PKS*PSZ-1:0] flat;
  logic [MSG_SZ-1:0]      msg;
  logic [ASZ-1:0]         m_src, m_dst;
  logic [DSZ-1:0]         m_dat;
  logic [RSZ-1:0]         m_red, red_calc;
  logic                   red_ok;
  logic                   sof;
  logic [PSZ-1:0]         payload;
  logic                   accept;
  logic                   seq_err, msg_done;
  logic                   load_out, redun_err;

  assign sof     = i_pakio[PSZ];
  assign payload = i_pakio[PSZ-1:0];
  assign accept  = (state_q == ST_COLLECT) && i_req && !i_ack_q;

  // Packets land low-first; anything beyond MSG_SZ in the last packet is dropped here.
  always_comb begin
    flat = '0;
    for (int k = 0; k < TOT_PKS; k++) begin
      flat[k*PSZ +: PSZ] = pk_q[k];
    end
  end

  assign msg   = flat[MSG_SZ-1:0];
  assign m_src = msg[ASZ-1:0];
  assign m_dst = msg[2*ASZ-1:ASZ];
  assign m_dat = msg[2*ASZ+DSZ-1:2*ASZ];
  assign m_red = msg[MSG_SZ-1:MSG_SZ-RSZ];

  calc_redun #(
    .ASZ(ASZ),
    .DSZ(DSZ),
    .RSZ(RSZ)
  ) u_redun (
    .src_i(m_src),
    .dst_i(m_dst),
    .dat_i(m_dat),
    .red_o(red_calc)
  );

  assign red_ok = (red_calc == m_red);

  // Packet sequencing: a stray sof restarts the message, an orphan non-sof is swallowed.
  always_comb begin
    pk_d     = pk_q;
    pk_cnt_d = pk_cnt_q;
    seq_err  = 1'b0;
    msg_done = 1'b0;
    if (accept) begin
      if (sof) begin
        seq_err = (pk_cnt_q != '0);
        pk_d[0] = payload;
        if (TOT_PKS == 1) begin
          msg_done = 1'b1;
        end else begin
          pk_cnt_d = CW'(1);
        end
      end else if (pk_cnt_q == '0) begin
        seq_err = 1'b1;
      end else begin
        pk_d[pk_cnt_q] = payload;
        if (pk_cnt_q == LAST_PK) begin
          pk_cnt_d = '0;
          msg_done = 1'b1;
        end else begin
          pk_cnt_d = pk_cnt_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_COLLECT: if (msg_done) state_d = ST_CHECK;
      ST_CHECK:   state_d = red_ok ? ST_SEND : ST_COLLECT;
      ST_SEND:    if (o_ack) state_d = ST_DRAIN;
      ST_DRAIN:   if (!o_ack) state_d = ST_COLLECT;
      default:    state_d = ST_COLLECT;
    endcase
  end

  always_comb begin
    o_req     = 1'b0;
    load_out  = 1'b0;
    redun_err = 1'b0;
    case (state_q)
      ST_CHECK: begin
        load_out  = red_ok;
        redun_err = !red_ok;
      end
      ST_SEND:  o_req = 1'b1;
      default:  ;
    endcase
  end

  // The ack of the final packet still falls while the FSM is busy; only new accepts are held off.
  always_comb begin
    i_ack_d = i_ack_q;
    if (accept) begin
      i_ack_d = 1'b1;
    end else if (!i_req) begin
      i_ack_d = 1'b0;
    end
  end

  always_comb begin
    err_seq_d   = err_seq_q | seq_err;
    err_redun_d = err_redun_q | redun_err;
    err_cnt_d   = err_cnt_q;
    if ((seq_err || redun_err) && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pk_cnt_q    <= '0;
      i_ack_q     <= 1'b0;
      src_q       <= '0;
      dst_q       <= '0;
      dat_q       <= '0;
      red_q       <= '0;
      err_redun_q <= 1'b0;
      err_seq_q   <= 1'b0;
      err_cnt_q   <= '0;
      for (int k = 0; k < TOT_PKS; k++) begin
        pk_q[k] <= '0;
      end
    end else begin
      pk_cnt_q    <= pk_cnt_d;
      i_ack_q     <= i_ack_d;
      err_redun_q <= err_redun_d;
      err_seq_q   <= err_seq_d;
      err_cnt_q   <= err_cnt_d;
      pk_q        <= pk_d;
      if (load_out) begin
        src_q <= m_src;
        dst_q <= m_dst;
        dat_q <= m_dat;
        red_q <= m_red;
      end
    end
  end

  assign i_ack     = i_ack_q;
  assign o_src     = src_q;
  assign o_dst     = dst_q;
  assign o_dat     = dat_q;
  assign o_red     = red_q;
  assign err_redun = err_redun_q;
  assign err_seq   = err_seq_q;
  assign err_cnt   = err_cnt_q;

endmodule
